// File: rtl/icache_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : icache_pkg
//  Description : Shared types, widths and PC field positions for the
//                direct-mapped instruction cache.
//                Provides the FSM state enum, the field widths and a
//                word-select helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package icache_pkg;

  localparam int TAG_W    = 3;
  localparam int IDX_W    = 3;
  localparam int OFF_W    = 2;
  localparam int BLOCK_W  = 128;
  localparam int WORD_W   = 32;
  localparam int NUM_SETS = 8;
  localparam int MADDR_W  = TAG_W + IDX_W;

  // Bit positions of the PC fields (PC[31:10] and PC[1:0] are don't-care)
  localparam int OFF_LSB  = 2;
  localparam int IDX_LSB  = 4;
  localparam int TAG_LSB  = 7;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    READ = 1'b1
  } state_e;

  // Pick one 32-bit word out of a line; word 0 lives in bits [31:0]
  function automatic logic [WORD_W-1:0] sel_word(input logic [BLOCK_W-1:0] blk,
                                                 input logic [OFF_W-1:0]   off);
    return blk[WORD_W*off +: WORD_W];
  endfunction

endpackage
`default_nettype wire

// File: rtl/icache_if.sv
`default_nettype none
// ============================================================================
//  Module      : icache_if
//  Description : CPU fetch port plus instruction-memory refill port.
//                slave  : cache side (receives PC and refill data)
//                master : CPU/memory side
//  Ports       : pc, instruction, busywait (CPU)
//                mem_read, mem_address, mem_readdata, mem_busywait (memory)
//  Revision    : 1.0 - initial release
// ============================================================================
interface icache_if;
  logic [31:0]  pc;
  logic [31:0]  instruction;
  logic         busywait;
  logic         mem_read;
  logic [5:0]   mem_address;
  logic [127:0] mem_readdata;
  logic         mem_busywait;

  modport slave (
    input  pc, mem_readdata, mem_busywait,
    output instruction, busywait, mem_read, mem_address
  );

  modport master (
    output pc, mem_readdata, mem_busywait,
    input  instruction, busywait, mem_read, mem_address
  );
endinterface
`default_nettype wire

// File: rtl/icache_store.sv
`default_nettype none
// ============================================================================
//  Module      : icache_store
//  Description : Valid/tag/data arrays of the direct-mapped cache.
//                Valid bits clear asynchronously; tag and data are plain
//                storage written on the refill edge.
//  Ports       : clk_i, rst_ni        clock, async active-low reset
//                we_i, widx_i, wtag_i, wdata_i   refill write port
//                ridx_i                 lookup index
//                rvalid_o, rtag_o, rdata_o       addressed line (comb.)
//  Revision    : 1.0 - initial release
// ============================================================================
module icache_store
  import icache_pkg::*;
(
  input  wire logic               clk_i,
  input  wire logic               rst_ni,
  input  wire logic               we_i,
  input  wire logic [IDX_W-1:0]   widx_i,
  input  wire logic [TAG_W-1:0]   wtag_i,
  input  wire logic [BLOCK_W-1:0] wdata_i,
  input  wire logic [IDX_W-1:0]   ridx_i,
  output logic                    rvalid_o,
  output logic [TAG_W-1:0]        rtag_o,
  output logic [BLOCK_W-1:0]      rdata_o
);

  logic [NUM_SETS-1:0] valid_q;
  logic [TAG_W-1:0]    tag_q  [NUM_SETS];
  logic [BLOCK_W-1:0]  data_q [NUM_SETS];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
    end else if (we_i) begin
      valid_q[widx_i] <= 1'b1;
    end
  end

  // Tag/data need no reset: a line is only consulted once its valid bit is set
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      tag_q[widx_i]  <= wtag_i;
      data_q[widx_i] <= wdata_i;
    end
  end

  assign rvalid_o = valid_q[ridx_i];
  assign rtag_o   = tag_q[ridx_i];
  assign rdata_o  = data_q[ridx_i];

endmodule
`default_nettype wire

// File: rtl/icache.sv
`default_nettype none
// ============================================================================
//  Module      : icache
//  Description : Direct-mapped read-only instruction cache, 8 lines of
//                4 words. Zero-cycle hits; misses stall the CPU with
//                busywait while one 128-bit block is refilled.
//  Ports       : clk_i   system clock
//                rst_ni  asynchronous active-low reset
//                bus     icache_if.slave (CPU fetch + memory refill)
//  Revision    : 1.0 - initial release
// ============================================================================
module icache
  import icache_pkg::*;
(
  input  wire logic clk_i,
  input  wire logic rst_ni,
  icache_if.slave   bus
);

  logic [IDX_W-1:0]   idx_w;
  logic [TAG_W-1:0]   tag_w;
  logic [OFF_W-1:0]   off_w;
  logic               unused_pc_bits;

  logic               line_valid_w;
  logic [TAG_W-1:0]   line_tag_w;
  logic [BLOCK_W-1:0] line_data_w;
  logic               hit_w;
  logic               refill_we_w;

  state_e             state_q, state_d;
  logic [MADDR_W-1:0] miss_q, miss_d;   // {tag, idx} of the outstanding miss

  assign idx_w = bus.pc[IDX_LSB +: IDX_W];
  assign tag_w = bus.pc[TAG_LSB +: TAG_W];
  assign off_w = bus.pc[OFF_LSB +: OFF_W];
  assign unused_pc_bits = ^{bus.pc[31:10], bus.pc[1:0]};

  icache_store u_store (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .we_i     (refill_we_w),
    .widx_i   (miss_q[IDX_W-1:0]),
    .wtag_i   (miss_q[MADDR_W-1:IDX_W]),
    .wdata_i  (bus.mem_readdata),
    .ridx_i   (idx_w),
    .rvalid_o (line_valid_w),
    .rtag_o   (line_tag_w),
    .rdata_o  (line_data_w)
  );

  assign hit_w = line_valid_w && (line_tag_w == tag_w);

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      miss_q  <= miss_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    miss_d  = miss_q;
    if (state_q == IDLE) begin
      if (!hit_w) begin
        state_d = READ;
        miss_d  = {tag_w, idx_w};
      end
    end else begin
      if (!bus.mem_busywait) begin
        state_d = IDLE;
      end
    end
  end

  // Output logic; while reset is held the CPU sees no stall and a zero word
  always_comb begin
    bus.busywait    = 1'b0;
    bus.mem_read    = 1'b0;
    bus.instruction = '0;
    refill_we_w     = 1'b0;
    if (rst_ni) begin
      if (state_q == IDLE) begin
        bus.busywait = !hit_w;
        if (hit_w) begin
          bus.instruction = sel_word(line_data_w, off_w);
        end
      end else begin
        bus.busywait = 1'b1;
        bus.mem_read = 1'b1;
        refill_we_w  = !bus.mem_busywait;
      end
    end
  end

  assign bus.mem_address = miss_q;

endmodule
`default_nettype wire

// File: tb/tb_icache.sv
`default_nettype none
// ============================================================================
//  Module      : tb_icache
//  Description : Self-checking bench for icache. Memory model returns block
//                a with word w = a*4 + w after LAT busy cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_icache;

  localparam int LAT = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  icache_if dif ();

  icache dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (dif.slave)
  );

  // ---------------- memory model ----------------
  int  mem_cnt = 0;
  int  rd_starts = 0;
  logic rd_prev = 1'b0;

  function automatic logic [127:0] blk(input logic [5:0] a);
    logic [127:0] b;
    for (int w = 0; w < 4; w++) b[32*w +: 32] = {24'h0, a, 2'(w)};
    return b;
  endfunction

  assign dif.mem_busywait = dif.mem_read && (mem_cnt != LAT);
  assign dif.mem_readdata = blk(dif.mem_address);

  always @(posedge clk) begin
    if (!dif.mem_read || mem_cnt == LAT) mem_cnt <= 0;
    else mem_cnt <= mem_cnt + 1;
    if (dif.mem_read && !rd_prev) rd_starts <= rd_starts + 1;
    rd_prev <= dif.mem_read;
  end

  // ---------------- checking ----------------
  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drive a missing PC just after a posedge; count stalled cycles at negedges
  task automatic miss_seq(input logic [31:0] pc, input logic [5:0] exp_addr,
                          input int exp_cycles, input string nm);
    int   n = 0;
    logic addr_ok = 1'b1;
    logic zero_ok = 1'b1;
    dif.pc = pc;
    @(negedge clk);
    while (dif.busywait && n < 60) begin
      n++;
      if (dif.mem_read && dif.mem_address !== exp_addr) addr_ok = 1'b0;
      if (dif.instruction !== 32'h0) zero_ok = 1'b0;
      @(negedge clk);
    end
    check({nm, " stall cycles"}, 32'(n), 32'(exp_cycles));
    check({nm, " mem_address"}, {31'h0, addr_ok}, 32'h1);
    check({nm, " zero instr in stall"}, {31'h0, zero_ok}, 32'h1);
  endtask

  task automatic hit_chk(input logic [31:0] pc, input logic [31:0] exp, input string nm);
    @(posedge clk); #1;
    dif.pc = pc;
    @(negedge clk);
    check({nm, " busywait"}, {31'h0, dif.busywait}, 32'h0);
    check({nm, " instr"}, dif.instruction, exp);
  endtask

  typedef struct {
    logic [31:0] pc;
    logic        busy;
    logic [31:0] instr;
  } vec_t;

  vec_t tab[8];

  initial begin
    int   n;
    int   rs;
    logic seen;
    logic [5:0] first_a, last_a;

    tab[0] = '{32'h0000_0000, 1'b0, 32'h0000_0000};
    tab[1] = '{32'h0000_0004, 1'b0, 32'h0000_0001};
    tab[2] = '{32'h0000_0008, 1'b0, 32'h0000_0002};
    tab[3] = '{32'h0000_000C, 1'b0, 32'h0000_0003};
    tab[4] = '{32'h0000_0008, 1'b0, 32'h0000_0002};
    tab[5] = '{32'h0000_0007, 1'b0, 32'h0000_0001};
    tab[6] = '{32'h0000_0400, 1'b0, 32'h0000_0000};
    tab[7] = '{32'hFFFF_FC0C, 1'b0, 32'h0000_0003};

    // Reset state, with a (missing) PC present
    dif.pc = 32'h0;
    repeat (2) @(negedge clk);
    check("reset busywait", {31'h0, dif.busywait}, 32'h0);
    check("reset mem_read", {31'h0, dif.mem_read}, 32'h0);
    check("reset mem_address", {26'h0, dif.mem_address}, 32'h0);
    check("reset instr", dif.instruction, 32'h0);

    // Cold miss right at reset release
    @(posedge clk); #1;
    rst_n = 1'b1;
    miss_seq(32'h000, 6'h00, 7, "cold");

    // Hits in line 0, including ignored PC bits; no memory traffic allowed
    rs = rd_starts;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      dif.pc = tab[i].pc;
      @(negedge clk);
      check($sformatf("tab%0d busywait", i), {31'h0, dif.busywait}, {31'h0, tab[i].busy});
      check($sformatf("tab%0d instr", i), dif.instruction, tab[i].instr);
    end
    @(posedge clk); #1;
    check("hit no mem_read", 32'(rd_starts - rs), 32'h0);

    // Conflict miss on index 0, then the original block misses again
    miss_seq(32'h080, 6'h08, 7, "conflict");
    hit_chk(32'h084, 32'h21, "conflict hit");
    @(posedge clk); #1;
    miss_seq(32'h000, 6'h00, 7, "re-miss");

    // PC changes while READ is outstanding
    @(posedge clk); #1;
    rs = rd_starts;
    dif.pc = 32'h010;
    @(negedge clk);
    @(posedge clk); #1;
    dif.pc = 32'h024;
    n = 1; seen = 1'b0; first_a = '0; last_a = '0;
    @(negedge clk);
    while (dif.busywait && n < 60) begin
      n++;
      if (dif.mem_read) begin
        if (!seen) first_a = dif.mem_address;
        seen = 1'b1;
        last_a = dif.mem_address;
      end
      @(negedge clk);
    end
    check("pcchg stall cycles", 32'(n), 32'd14);
    check("pcchg first addr", {26'h0, first_a}, 32'h01);
    check("pcchg second addr", {26'h0, last_a}, 32'h02);
    check("pcchg read count", 32'(rd_starts - rs), 32'd2);
    hit_chk(32'h010, 32'h04, "pcchg line1");
    hit_chk(32'h024, 32'h09, "pcchg line2");

    // Reset in the middle of a refill
    @(posedge clk); #1;
    dif.pc = 32'h030;
    @(negedge clk);
    @(negedge clk);
    check("midrst mem_read before", {31'h0, dif.mem_read}, 32'h1);
    #1 rst_n = 1'b0;
    #1;
    check("midrst mem_read", {31'h0, dif.mem_read}, 32'h0);
    check("midrst busywait", {31'h0, dif.busywait}, 32'h0);
    check("midrst instr", dif.instruction, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("midrst mem_address", {26'h0, dif.mem_address}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    miss_seq(32'h000, 6'h00, 7, "post-rst line0");
    @(posedge clk); #1;
    miss_seq(32'h030, 6'h03, 7, "post-rst line3");
    hit_chk(32'h030, 32'h0C, "line3 hit");
    hit_chk(32'h400, 32'h00, "ignored bits");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
